system_pio_input_debounce: RTL and testbench
============================================

Name: system_pio_input_debounce

Overview:
Input conditioner that sits directly upstream of the 8-bit edge-capturing input PIO. It takes raw asynchronous board inputs (push-buttons, DIP switches) and applies three steps: a two-flop synchronizer, a prescaled sampling tick, and a per-bit stability counter. The clean, debounced vector drives the PIO in_port, so that PIO's edge_capture register sees exactly one edge per physical press. It also provides one-cycle rise/fall pulses and an "any change" strobe for local logic.

Parameters:
WIDTH, 8, number of input bits (matches PIO in_port width)
PRESCALE, 50000, clock cycles per sample tick (>=1; 1 = tick every cycle)
STABLE_COUNT, 16, consecutive ticks a new level must persist before being accepted (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset, applied immediately, released synchronously by the system reset controller
raw_in  input  WIDTH  unsynchronized board inputs
bypass  input  1  1 = debounced follows sync stage directly (simulation/fast test); quasi-static
debounced  output  WIDTH  registered clean level, connects to PIO in_port
rise_pulse  output  WIDTH  one-cycle pulse per bit when debounced goes 0->1
fall_pulse  output  WIDTH  one-cycle pulse per bit when debounced goes 1->0
changed  output  1  one-cycle pulse, OR of rise_pulse|fall_pulse, registered

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (reset_n); every register clears on reset_n=0 regardless of clk.
- Reset values: sync1, sync2, debounced, rise_pulse, fall_pulse, changed, per-bit counters and prescaler all 0.
- Synchronizer: sync1 <= raw_in; sync2 <= sync1, every cycle. This gives 2-cycle latency into the compare logic.
- Prescaler: counter 0..PRESCALE-1, increments every cycle and wraps to 0. tick=1 combinationally when the counter equals PRESCALE-1. With PRESCALE=1, tick is constantly 1. The prescaler is not affected by bypass.
- Per-bit counter cnt[i], width clog2(STABLE_COUNT+1). Let mism[i] = sync2[i] != debounced[i].
  - Any cycle with mism[i]=0: cnt[i] <= 0. A glitch back to the old level restarts qualification.
  - tick=1 with mism[i]=1 and cnt[i] < STABLE_COUNT-1: cnt[i] <= cnt[i]+1.
  - tick=1 with mism[i]=1 and cnt[i] == STABLE_COUNT-1: debounced[i] <= sync2[i] and cnt[i] <= 0. In the same edge, rise_pulse[i] <= sync2[i] and fall_pulse[i] <= ~sync2[i].
  - Net effect: a level is accepted on the STABLE_COUNT-th consecutive tick at which it differs from debounced.
- Bypass=1: debounced <= sync2 every cycle, and all cnt <= 0. rise/fall pulses are generated from (sync2 & ~debounced) and (~sync2 & debounced) in the same edge.
- Pulses: rise_pulse/fall_pulse are high exactly one cycle, coincident with the first cycle debounced shows the new value. At most one of rise/fall is active per bit per cycle. Otherwise they are 0. changed <= |(next rise | next fall), so it is aligned with the pulses.
- Bits are fully independent. Simultaneous qualification of several bits in one tick updates all of them in the same cycle, and changed pulses once.
- Counter saturation cannot occur: the counter is bounded by STABLE_COUNT-1 and then cleared.
- Reset mid-qualification: counters clear, debounced returns to 0, and no pulse is emitted. After release, a held-high input requalifies from scratch.
- Latency, bypass=0: from raw_in change to debounced change is 2 cycles plus the time to STABLE_COUNT ticks. This is between (STABLE_COUNT-1)*PRESCALE+3 and STABLE_COUNT*PRESCALE+2 cycles, depending on prescaler phase.

Test Plan:
1. Use PRESCALE=4, STABLE_COUNT=3. Assert reset_n=0 mid-run with raw_in=8'hFF -> all outputs read 0 asynchronously (before the next clk edge). After release, keep raw_in=8'hFF -> debounced=8'hFF within 11..14 cycles; rise_pulse=8'hFF and changed=1 for exactly one cycle; fall_pulse stays 0.
2. Same parameters. Start from debounced=0, then drive raw_in[0] as a chatter burst: 1 for 6 cycles, 0 for 2, 1 for 6, then back to 0 -> debounced[0] never rises; rise_pulse[0] and changed stay 0.
3. Start with debounced=8'h01. Drop raw_in[0] to 0 and simultaneously raise raw_in[7] to 1, then hold both -> both bits update in the same cycle: debounced=8'h80, rise_pulse=8'h80 and fall_pulse=8'h01 for one cycle, changed pulses once.
4. Use PRESCALE=1, STABLE_COUNT=1. Toggle raw_in[3] each 3 cycles -> debounced[3] follows with exactly 3-cycle latency; one pulse per transition.
5. bypass=1, PRESCALE=4. Pulse raw_in=8'h0F for a single cycle -> debounced=8'h0F for exactly one cycle, 3 cycles later; rise_pulse=8'h0F then fall_pulse=8'h0F on the next cycle.
6. Connect debounced to the PIO in_port. Press bit 2 with 10 bounces and release -> PIO edge_capture[2] is set once. Writing PIO register 3 clears it, and it stays clear until the next qualified press.

Source files
------------

// File: rtl/system_pio_input_debounce.sv
// Input conditioner for the edge-capturing PIO: two-flop synchronizer, prescaled
// sample tick and per-bit stability counters, with one-cycle rise/fall/changed strobes.
module system_pio_input_debounce #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 50000,
    parameter int STABLE_COUNT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             bypass,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] deb_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // Stage p0/p1: metastability synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    // With PRESCALE=1 the counter sits at 0 == PRE_LAST, so tick is constantly high.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Qualification: any cycle back at the accepted level restarts the count.
    always_comb begin
        deb_nxt = debounced;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (bypass) begin
                deb_nxt[i] = sync_p1[i];
            end else if (sync_p1[i] != debounced[i]) begin
                if (!tick) begin
                    cnt_nxt[i] = cnt[i];
                end else if (cnt[i] == CNT_LAST) begin
                    deb_nxt[i] = sync_p1[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
        rise_nxt = deb_nxt & ~debounced;
        fall_nxt = ~deb_nxt & debounced;
    end

    // Output stage: level and strobes update on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            changed    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            debounced  <= deb_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            changed    <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_system_pio_input_debounce.sv
// Bench for system_pio_input_debounce: two instances (PRESCALE=4/STABLE_COUNT=3 and 1/1),
// directed scenarios plus randomized traffic checked every cycle against a tick-counting model.
module tb_system_pio_input_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] raw_a, raw_b;
    logic       byp_a, byp_b;
    logic [7:0] deb_a, rise_a, fall_a;
    logic [7:0] deb_b, rise_b, fall_b;
    logic       chg_a, chg_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    system_pio_input_debounce #(.WIDTH(8), .PRESCALE(4), .STABLE_COUNT(3)) dut_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_a), .bypass(byp_a),
        .debounced(deb_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .changed(chg_a)
    );

    system_pio_input_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_COUNT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_b), .bypass(byp_b),
        .debounced(deb_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .changed(chg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A new level is accepted on the edge at which the number of
    // sample ticks seen since the mismatch run began reaches STABLE_COUNT; ticks fall
    // on edges k with k mod P == P-1, k counted from reset release.
    int         m_p  [2] = '{4, 1};
    int         m_sc [2] = '{3, 1};
    logic [7:0] m_s1 [2], m_s2 [2], m_deb [2], m_rise [2], m_fall [2];
    logic       m_chg[2];
    int         m_k  [2];
    int         m_run[2][8];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_s1[d] = '0; m_s2[d] = '0; m_deb[d] = '0;
            m_rise[d] = '0; m_fall[d] = '0; m_chg[d] = 1'b0; m_k[d] = 0;
            for (int i = 0; i < 8; i++) m_run[d][i] = -1;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] raw, input logic byp);
        logic [7:0] s2, nd;
        int ticks;
        s2 = m_s2[d];
        nd = m_deb[d];
        for (int i = 0; i < 8; i++) begin
            if (byp) begin
                nd[i] = s2[i];
                m_run[d][i] = -1;
            end else if (s2[i] == m_deb[d][i]) begin
                m_run[d][i] = -1;
            end else begin
                if (m_run[d][i] < 0) m_run[d][i] = m_k[d];
                ticks = (m_k[d] + 1) / m_p[d] - m_run[d][i] / m_p[d];
                if (ticks >= m_sc[d]) begin
                    nd[i] = s2[i];
                    m_run[d][i] = -1;
                end
            end
        end
        m_rise[d] = nd & ~m_deb[d];
        m_fall[d] = ~nd & m_deb[d];
        m_chg[d]  = |(m_rise[d] | m_fall[d]);
        m_deb[d]  = nd;
        m_s2[d]   = m_s1[d];
        m_s1[d]   = raw;
        m_k[d]++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0, raw_a, byp_a);
            model_step(1, raw_b, byp_b);
        end
    end

    always @(negedge clk) begin
        check("a_debounced", {24'h0, deb_a}, {24'h0, m_deb[0]});
        check("a_rise", {24'h0, rise_a}, {24'h0, m_rise[0]});
        check("a_fall", {24'h0, fall_a}, {24'h0, m_fall[0]});
        check("a_changed", {31'h0, chg_a}, {31'h0, m_chg[0]});
        check("b_debounced", {24'h0, deb_b}, {24'h0, m_deb[1]});
        check("b_rise", {24'h0, rise_b}, {24'h0, m_rise[1]});
        check("b_fall", {24'h0, fall_b}, {24'h0, m_fall[1]});
        check("b_changed", {31'h0, chg_b}, {31'h0, m_chg[1]});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first, n_rise, n_chg, n_fall, n_both, n_pulse, ec_sets;
        logic ec, prev2;
        logic hist[0:39];

        reset_n = 1'b0; raw_a = '0; raw_b = '0; byp_a = 1'b0; byp_b = 1'b0;
        cycles(3);
        reset_n = 1'b1;

        // Scenario 1: async reset mid-run, then requalify a held-high input.
        raw_a = 8'hFF; raw_b = 8'h5A;
        cycles(20);
        check("t1_pre_reset_deb", {24'h0, deb_a}, 32'hFF);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_deb_a", {24'h0, deb_a}, 32'h0);
        check("t1_async_pulses_a", {16'h0, rise_a, fall_a}, 32'h0);
        check("t1_async_chg_a", {31'h0, chg_a}, 32'h0);
        check("t1_async_deb_b", {24'h0, deb_b}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        first = -1; n_rise = 0; n_chg = 0; n_fall = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (deb_a == 8'hFF && first < 0) begin
                first = n;
                check("t1_rise_with_level", {24'h0, rise_a}, 32'hFF);
            end
            if (rise_a == 8'hFF) n_rise++;
            if (chg_a) n_chg++;
            if (fall_a != 8'h00) n_fall++;
        end
        check("t1_latency", first, 12);
        check("t1_latency_in_range", {31'h0, (first >= 11 && first <= 14)}, 32'h1);
        check("t1_rise_count", n_rise, 1);
        check("t1_chg_count", n_chg, 1);
        check("t1_fall_count", n_fall, 0);

        // Scenario 2: chatter on bit 0 never qualifies.
        raw_a = 8'h00; raw_b = 8'h00;
        cycles(20);
        n_rise = 0; n_chg = 0; first = 0;
        raw_a[0] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 5) raw_a[0] = 1'b0;
            if (n == 7) raw_a[0] = 1'b1;
            if (n == 13) raw_a[0] = 1'b0;
            if (rise_a[0]) n_rise++;
            if (chg_a) n_chg++;
            if (deb_a[0]) first++;
        end
        check("t2_rise0_count", n_rise, 0);
        check("t2_chg_count", n_chg, 0);
        check("t2_deb0_high_cycles", first, 0);

        // Scenario 3: simultaneous fall on bit 0 and rise on bit 7.
        raw_a = 8'h01;
        cycles(20);
        check("t3_start_deb", {24'h0, deb_a}, 32'h01);
        raw_a = 8'h80;
        n_chg = 0; n_both = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (chg_a) n_chg++;
            if (rise_a == 8'h80 && fall_a == 8'h01 && chg_a && deb_a == 8'h80) n_both++;
        end
        check("t3_chg_count", n_chg, 1);
        check("t3_joint_pulse", n_both, 1);
        check("t3_end_deb", {24'h0, deb_a}, 32'h80);

        // Scenario 4: PRESCALE=1, STABLE_COUNT=1 gives a fixed 3-cycle latency.
        raw_b = 8'h00;
        cycles(5);
        n_pulse = 0;
        for (int m = 0; m < 36; m++) begin
            @(negedge clk);
            if (m >= 3) check("t4_deb3_latency", {31'h0, deb_b[3]}, {31'h0, hist[m-3]});
            if (rise_b[3] || fall_b[3]) n_pulse++;
            if (m < 30 && m % 3 == 0) raw_b[3] = ~raw_b[3];
            hist[m] = raw_b[3];
        end
        check("t4_pulse_count", n_pulse, 10);

        // Scenario 5: bypass passes a single-cycle pulse straight through.
        raw_a = 8'h00; byp_a = 1'b1;
        cycles(10);
        raw_a = 8'h0F;
        @(negedge clk);
        raw_a = 8'h00;
        @(negedge clk);
        check("t5_deb_n2", {24'h0, deb_a}, 32'h0);
        @(negedge clk);
        check("t5_deb_n3", {24'h0, deb_a}, 32'h0F);
        check("t5_rise_n3", {16'h0, rise_a, fall_a}, 32'h0F00);
        @(negedge clk);
        check("t5_deb_n4", {24'h0, deb_a}, 32'h0);
        check("t5_fall_n4", {16'h0, rise_a, fall_a}, 32'h000F);
        byp_a = 1'b0;
        cycles(5);

        // Scenario 6: bounced press/release seen by a rising-edge capture register.
        ec = 1'b0; prev2 = deb_a[2]; ec_sets = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int b = 0; b < 10; b++) begin
                raw_a[2] = ~raw_a[2];
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    if (deb_a[2] && !prev2) begin ec = 1'b1; ec_sets++; end
                    prev2 = deb_a[2];
                end
            end
            raw_a[2] = (ph % 2 == 0) ? 1'b1 : 1'b0;
            for (int n = 0; n < 25; n++) begin
                @(negedge clk);
                if (deb_a[2] && !prev2) begin ec = 1'b1; ec_sets++; end
                prev2 = deb_a[2];
                if (ph == 0 && n == 20) begin
                    check("t6_capture_set", {31'h0, ec}, 32'h1);
                    ec = 1'b0;
                end
            end
            if (ph == 0) check("t6_single_set", ec_sets, 1);
            if (ph == 1) check("t6_clear_holds", {31'h0, ec}, 32'h0);
        end
        check("t6_second_press", {31'h0, ec}, 32'h1);
        check("t6_total_sets", ec_sets, 2);

        // Randomized traffic, checked every cycle by the compare process.
        for (int it = 0; it < 2500; it++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) raw_a[b] = ~raw_a[b];
            end
            if ($urandom_range(0, 2) == 0) raw_b = raw_b ^ 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) byp_a = ~byp_a;
            if ($urandom_range(0, 299) == 0) byp_b = ~byp_b;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
